// File: rtl/adapt_thresh_seq_pkg.sv
// rtl/adapt_thresh_seq_pkg.sv - shared state encoding, mode codes and lag derivation
package adapt_thresh_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] MODE_ADAPT  = 2'd0;
    localparam logic [1:0] MODE_FIXED  = 2'd1;
    localparam logic [1:0] MODE_BYPASS = 2'd2;

    // A 5x5 window centre trails the input by two lines plus two pixels.
    function automatic int calc_lag(input int img_w);
        return 2 * img_w + 2;
    endfunction

    // The reserved code behaves as adaptive.
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        case (mode)
            MODE_FIXED:  return MODE_FIXED;
            MODE_BYPASS: return MODE_BYPASS;
            default:     return MODE_ADAPT;
        endcase
    endfunction

endpackage

// File: rtl/adapt_thresh_seq_pos_ctr.sv
// rtl/adapt_thresh_seq_pos_ctr.sv - centre-pixel row/col counter with border flag
module adapt_thresh_pos_ctr
    import adapt_thresh_seq_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int RW    = $clog2(IMG_H),
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_adv,
    output logic [RW-1:0] o_row,
    output logic [CW-1:0] o_col,
    output logic          o_win_ok
);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_adv) begin
            if (r_col == CW'(IMG_W - 1)) begin
                r_col <= '0;
                r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row    = r_row;
    assign o_col    = r_col;
    assign o_win_ok = (r_row >= RW'(2)) && (r_row <= RW'(IMG_H - 3)) &&
                      (r_col >= CW'(2)) && (r_col <= CW'(IMG_W - 3));

endmodule

// File: rtl/adapt_thresh_seq.sv
// rtl/adapt_thresh_seq.sv - frame sequencer for the 5x5 window-mean adaptive threshold
module adapt_thresh_seq
    import adapt_thresh_seq_pkg::*;
#(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int PIPE_LAT = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [1:0]               i_mode,
    input  logic [7:0]               i_fix_thr,
    input  logic                     i_pix_valid,
    output logic                     o_pix_ready,
    output logic                     o_dp_en,
    output logic                     o_dp_clr,
    output logic                     o_dp_zero,
    output logic [1:0]               o_mode,
    output logic [7:0]               o_thr,
    output logic                     o_out_valid,
    output logic                     o_win_ok,
    output logic [$clog2(IMG_H)-1:0] o_row,
    output logic [$clog2(IMG_W)-1:0] o_col,
    output logic                     o_busy,
    output logic                     o_frame_done
);

    localparam int RW   = $clog2(IMG_H);
    localparam int CW   = $clog2(IMG_W);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int LAG  = calc_lag(IMG_W);
    localparam int IN_W = $clog2(NPIX + 1);
    localparam int FL_W = $clog2(LAG + 1);
    localparam int DR_W = $clog2(PIPE_LAT + 1);
    localparam int PE_W = 2 + RW + CW;

    state_t                     r_state;
    state_t                     w_next;
    logic [IN_W-1:0]            r_in_cnt;
    logic [FL_W-1:0]            r_fl_cnt;
    logic [FL_W-1:0]            r_lag_cnt;
    logic [DR_W-1:0]            r_dr_cnt;
    logic [1:0]                 r_mode;
    logic [7:0]                 r_thr;
    logic [PIPE_LAT-1:0][PE_W-1:0] r_pipe;

    logic          w_xfer;
    logic          w_last_pix;
    logic          w_fl_end;
    logic          w_dr_end;
    logic          w_adv;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic          w_win_ok;

    assign w_xfer     = (r_state == ST_RUN) && i_pix_valid;
    assign w_last_pix = w_xfer && (r_in_cnt == IN_W'(NPIX - 1));
    assign w_fl_end   = (r_fl_cnt == FL_W'(LAG - 1));
    assign w_dr_end   = (r_dr_cnt == DR_W'(PIPE_LAT - 1));
    // Enables beyond the first LAG ones each land a new window centre.
    assign w_adv      = o_dp_en && (r_lag_cnt == FL_W'(LAG));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_CLEAR;
            ST_CLEAR: w_next = ST_RUN;
            ST_RUN:   if (w_last_pix) w_next = ST_FLUSH;
            ST_FLUSH: if (w_fl_end) w_next = ST_DRAIN;
            ST_DRAIN: if (w_dr_end) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_pix_ready  = 1'b0;
        o_dp_en      = 1'b0;
        o_dp_clr     = 1'b0;
        o_dp_zero    = 1'b0;
        o_frame_done = 1'b0;
        o_busy       = (r_state != ST_IDLE);
        case (r_state)
            ST_CLEAR: o_dp_clr = 1'b1;
            ST_RUN: begin
                o_pix_ready = 1'b1;
                o_dp_en     = i_pix_valid;
            end
            ST_FLUSH: begin
                o_dp_en   = 1'b1;
                o_dp_zero = 1'b1;
            end
            ST_DRAIN: o_frame_done = w_dr_end;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_in_cnt  <= '0;
            r_fl_cnt  <= '0;
            r_lag_cnt <= '0;
            r_dr_cnt  <= '0;
            r_mode    <= '0;
            r_thr     <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_in_cnt  <= '0;
            r_fl_cnt  <= '0;
            r_lag_cnt <= '0;
            r_dr_cnt  <= '0;
            r_mode    <= norm_mode(i_mode);
            r_thr     <= i_fix_thr;
        end else begin
            if (w_xfer) r_in_cnt <= r_in_cnt + 1'b1;
            if (r_state == ST_FLUSH) r_fl_cnt <= r_fl_cnt + 1'b1;
            if (r_state == ST_DRAIN) r_dr_cnt <= r_dr_cnt + 1'b1;
            if (o_dp_en && (r_lag_cnt != FL_W'(LAG))) r_lag_cnt <= r_lag_cnt + 1'b1;
        end
    end

    adapt_thresh_pos_ctr #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .RW    (RW),
        .CW    (CW)
    ) u_pos_ctr (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (o_dp_clr),
        .i_adv    (w_adv),
        .o_row    (w_row),
        .o_col    (w_col),
        .o_win_ok (w_win_ok)
    );

    // Tags travel alongside the datapath so they emerge with the matching result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= {w_adv, w_win_ok, w_row, w_col};
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign {o_out_valid, o_win_ok, o_row, o_col} = r_pipe[PIPE_LAT-1];
    assign o_mode = r_mode;
    assign o_thr  = r_thr;

endmodule

// File: tb/tb_adapt_thresh_seq.sv
// tb/tb_adapt_thresh_seq.sv - directed scoreboard bench for adapt_thresh_seq
module tb_adapt_thresh_seq;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int PL  = 2;
    localparam int N   = W * H;
    localparam int LAG = 2 * W + 2;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
        logic       win;
        logic [1:0] mode;
        logic [7:0] thr;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [1:0] i_mode;
    logic [7:0] i_fix_thr;
    logic       i_pix_valid;
    logic       o_pix_ready, o_dp_en, o_dp_clr, o_dp_zero;
    logic [1:0] o_mode;
    logic [7:0] o_thr;
    logic       o_out_valid, o_win_ok;
    logic [2:0] o_row, o_col;
    logic       o_busy, o_frame_done;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   n_res = 0, n_win = 0, n_done = 0, n_zero = 0, n_clr = 0, n_xfer = 0;
    int   last_res_cyc = 0, done_cyc = 0, last_zero_cyc = 0;
    int   exp_idx;
    logic [1:0] exp_mode;
    logic [7:0] exp_thr;
    exp_t sb[$];

    adapt_thresh_seq #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(PL)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_fix_thr    (i_fix_thr),
        .i_pix_valid  (i_pix_valid),
        .o_pix_ready  (o_pix_ready),
        .o_dp_en      (o_dp_en),
        .o_dp_clr     (o_dp_clr),
        .o_dp_zero    (o_dp_zero),
        .o_mode       (o_mode),
        .o_thr        (o_thr),
        .o_out_valid  (o_out_valid),
        .o_win_ok     (o_win_ok),
        .o_row        (o_row),
        .o_col        (o_col),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        int r, c;
        r = exp_idx / W;
        c = exp_idx % W;
        e.row  = 3'(r);
        e.col  = 3'(c);
        e.win  = (r >= 2) && (r <= H - 3) && (c >= 2) && (c <= W - 3);
        e.mode = exp_mode;
        e.thr  = exp_thr;
        sb.push_back(e);
        exp_idx++;
    endtask

    always @(negedge i_clk) begin
        if (o_out_valid) begin
            exp_t e;
            n_res++;
            last_res_cyc = cyc;
            if (o_win_ok) n_win++;
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL sb_underflow observed=result expected=none row=%0d col=%0d", o_row, o_col);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("res_row", o_row, e.row);
                check("res_col", o_col, e.col);
                check("res_win_ok", o_win_ok, e.win);
                check("res_mode", o_mode, e.mode);
                check("res_thr", o_thr, e.thr);
            end
        end
        if (o_frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (o_dp_zero) begin
            n_zero++;
            last_zero_cyc = cyc;
        end
        if (o_dp_clr) n_clr++;
        if (o_pix_ready && i_pix_valid) n_xfer++;
    end

    task automatic run_frame(input bit toggle, input logic [1:0] mode, input logic [7:0] thr,
                             input bit chg, input bit inj, input int rst_at);
        int  r0, d0, z0, c0, w0, x0, sent;
        bit  got;
        r0 = n_res; d0 = n_done; z0 = n_zero; c0 = n_clr; w0 = n_win; x0 = n_xfer;
        exp_mode  = (mode == 2'd3) ? 2'd0 : mode;
        exp_thr   = thr;
        exp_idx   = 0;
        i_mode    = mode;
        i_fix_thr = thr;
        i_start   = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        check("clear_pulse", o_dp_clr, 1);
        check("clear_busy", o_busy, 1);
        @(posedge i_clk); #1;
        sent = 0;
        for (int i = 0; sent < N; i++) begin
            i_pix_valid = toggle ? ((i % 2) == 0) : 1'b1;
            i_start     = inj && (i == 5);
            if (chg && i == 20) begin
                i_mode    = 2'd0;
                i_fix_thr = 8'h10;
            end
            @(negedge i_clk);
            check("run_ready", o_pix_ready, 1);
            check("run_dp_en", o_dp_en, i_pix_valid);
            if (i_pix_valid) begin
                push_expected();
                sent++;
            end
            if (rst_at != 0 && sent == rst_at) begin
                i_rst = 1'b1;
                #1;
                check("rst_busy", o_busy, 0);
                check("rst_ready", o_pix_ready, 0);
                check("rst_out_valid", o_out_valid, 0);
                @(negedge i_clk);
                check("rst_busy_next", o_busy, 0);
                check("rst_mode", o_mode, 0);
                @(posedge i_clk); #1;
                i_rst = 1'b0;
                i_pix_valid = 1'b0;
                sb.delete();
                repeat (5) @(posedge i_clk);
                #1;
                check("rst_no_done", n_done - d0, 0);
                check("rst_idle", o_busy, 0);
                return;
            end
            @(posedge i_clk); #1;
        end
        i_pix_valid = 1'b0;
        i_start     = inj;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge i_clk);
            if (o_frame_done) got = 1'b1;
            else begin
                @(posedge i_clk); #1;
            end
        end
        i_start = 1'b0;
        check("done_seen", got, 1);
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        check("end_busy", o_busy, 0);
        check("xfer_count", n_xfer - x0, N);
        check("result_count", n_res - r0, N);
        check("sb_empty", sb.size(), 0);
        check("done_count", n_done - d0, 1);
        check("done_align_res", done_cyc - last_res_cyc, 0);
        check("done_align_flush", done_cyc - last_zero_cyc, PL);
        check("flush_cycles", n_zero - z0, LAG);
        check("clear_count", n_clr - c0, 1);
        check("win_ok_count", n_win - w0, 16);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_mode = 2'd0; i_fix_thr = 8'd0; i_pix_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_busy", o_busy, 0);
        check("reset_ready", o_pix_ready, 0);
        check("reset_out_valid", o_out_valid, 0);
        check("reset_mode", o_mode, 0);
        check("reset_thr", o_thr, 0);
        check("reset_row", o_row, 0);
        check("reset_col", o_col, 0);
        check("reset_done", o_frame_done, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("idle_clr", o_dp_clr, 0);
        check("idle_dp_en", o_dp_en, 0);

        run_frame(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 0);
        run_frame(1'b1, 2'd2, 8'h33, 1'b0, 1'b0, 0);
        run_frame(1'b0, 2'd1, 8'h80, 1'b1, 1'b0, 0);
        run_frame(1'b0, 2'd0, 8'h10, 1'b0, 1'b0, 0);
        run_frame(1'b0, 2'd3, 8'h5a, 1'b0, 1'b1, 0);
        run_frame(1'b0, 2'd1, 8'h44, 1'b0, 1'b0, 20);
        run_frame(1'b1, 2'd1, 8'h44, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
